// File: rtl/dp_pkg.sv
// dp_pkg: shared encodings for the datapath_seq block.
//   ALU op codes, shifter codes, one-hot writeback selects and the
//   sequencer state enum (IDLE, FETCH, EXEC, WB).
package dp_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    localparam logic [3:0] VSEL_MDATA = 4'b1000;
    localparam logic [3:0] VSEL_IMM   = 4'b0100;
    localparam logic [3:0] VSEL_PC    = 4'b0010;
    localparam logic [3:0] VSEL_C     = 4'b0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        WB    = 2'd3
    } state_t;

endpackage

// File: rtl/datapath_seq_if.sv
// datapath_seq_if: command handshake plus memory/PC inputs and result outputs
// of datapath_seq.
//   master modport: command source (decoder / testbench)
//   slave  modport: datapath_seq
//   cmd_valid/cmd_ready handshake, cmd_* command fields, mdata, pc,
//   done pulse, status {Z,N,V}, dp_out (register C).
interface datapath_seq_if #(
    parameter int W       = 16,
    parameter int NREG    = 8,
    parameter int PC_W    = 9,
    parameter int IMM_B_W = 5,
    parameter int IMM_V_W = 8
);
    localparam int RA = $clog2(NREG);

    logic               cmd_valid;
    logic               cmd_ready;
    logic [RA-1:0]      cmd_rn;
    logic [RA-1:0]      cmd_rm;
    logic [RA-1:0]      cmd_rd;
    logic [1:0]         cmd_shift;
    logic               cmd_asel;
    logic               cmd_bsel;
    logic [1:0]         cmd_aluop;
    logic [3:0]         cmd_vsel;
    logic               cmd_write;
    logic               cmd_loads;
    logic [IMM_B_W-1:0] cmd_imm_b;
    logic [IMM_V_W-1:0] cmd_imm_v;
    logic [W-1:0]       mdata;
    logic [PC_W-1:0]    pc;
    logic               done;
    logic [2:0]         status;
    logic [W-1:0]       dp_out;

    modport master (
        output cmd_valid, cmd_rn, cmd_rm, cmd_rd, cmd_shift, cmd_asel, cmd_bsel,
               cmd_aluop, cmd_vsel, cmd_write, cmd_loads, cmd_imm_b, cmd_imm_v,
               mdata, pc,
        input  cmd_ready, done, status, dp_out
    );

    modport slave (
        input  cmd_valid, cmd_rn, cmd_rm, cmd_rd, cmd_shift, cmd_asel, cmd_bsel,
               cmd_aluop, cmd_vsel, cmd_write, cmd_loads, cmd_imm_b, cmd_imm_v,
               mdata, pc,
        output cmd_ready, done, status, dp_out
    );

endinterface

// File: rtl/dp_regfile.sv
// dp_regfile: NREG x W register file.
//   clk, reset       : clock, synchronous active-high clear of every entry
//   we, waddr, wdata : single synchronous write port
//   raddr_a/rdata_a,
//   raddr_b/rdata_b  : two asynchronous read ports
module dp_regfile #(
    parameter int W    = 16,
    parameter int NREG = 8,
    parameter int RA   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [RA-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [RA-1:0] raddr_a,
    input  logic [RA-1:0] raddr_b,
    output logic [W-1:0]  rdata_a,
    output logic [W-1:0]  rdata_b
);

    logic [W-1:0] regs [NREG];

    // Reset wins over a same-cycle write so an aborted command never lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/datapath_seq.sv
// datapath_seq: register file + A/B/C pipeline registers + shifter + ALU +
// status flags, run by a 4-state sequencer (IDLE -> FETCH -> EXEC -> WB)
// that takes one command per cmd_valid/cmd_ready handshake.
//   clk, reset : clock, synchronous active-high reset
//   bus        : datapath_seq_if.slave (command fields, mdata, pc, done,
//                status {Z,N,V}, dp_out = register C)
// Optional feature macro DATAPATH_SAT_EN: ADD/SUB saturate on signed
// overflow (V still set). Undefined: wraparound arithmetic.
module datapath_seq
    import dp_pkg::*;
#(
    parameter int W       = 16,
    parameter int NREG    = 8,
    parameter int PC_W    = 9,
    parameter int IMM_B_W = 5,
    parameter int IMM_V_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    datapath_seq_if.slave  bus
);

    localparam int RA = $clog2(NREG);

    state_t state;

    // latched command
    logic [RA-1:0]      rn_q, rm_q, rd_q;
    logic [1:0]         shift_q, aluop_q;
    logic               asel_q, bsel_q, write_q, loads_q;
    logic [3:0]         vsel_q;
    logic [IMM_B_W-1:0] imm_b_q;
    logic [IMM_V_W-1:0] imm_v_q;

    logic [W-1:0] a_q, b_q, c_q;
    logic [2:0]   status_q;
    logic         done_q, ready_q;

    logic [W-1:0] rdata_a, rdata_b, wb_data;
    logic [W-1:0] a_op, b_sh, b_op, sum, diff, alu_res;
    logic         ovf;
    logic         rf_we;

    assign rf_we = (state == WB) && write_q;

    dp_regfile #(.W(W), .NREG(NREG), .RA(RA)) u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (rd_q),
        .wdata   (wb_data),
        .raddr_a (rn_q),
        .raddr_b (rm_q),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    // Shifter acts on the B register only; the B immediate bypasses it.
    always_comb begin
        a_op = asel_q ? '0 : a_q;
        case (shift_q)
            SH_LSL:  b_sh = {b_q[W-2:0], 1'b0};
            SH_LSR:  b_sh = {1'b0, b_q[W-1:1]};
            SH_ASR:  b_sh = {b_q[W-1], b_q[W-1:1]};
            default: b_sh = b_q;
        endcase
        b_op = bsel_q ? W'($signed(imm_b_q)) : b_sh;
        sum  = a_op + b_op;
        diff = a_op - b_op;
        ovf     = 1'b0;
        alu_res = '0;
        case (aluop_q)
            ALU_ADD: begin
                alu_res = sum;
                ovf = (a_op[W-1] == b_op[W-1]) && (sum[W-1] != a_op[W-1]);
            end
            ALU_SUB: begin
                alu_res = diff;
                ovf = (a_op[W-1] != b_op[W-1]) && (diff[W-1] != a_op[W-1]);
            end
            ALU_AND: alu_res = a_op & b_op;
            default: alu_res = ~b_op;
        endcase
`ifdef DATAPATH_SAT_EN
        // On overflow the true result has the sign of A, so clamp toward it.
        if (ovf) alu_res = a_op[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    end

    // Non-one-hot selects fall back to C.
    always_comb begin
        case (vsel_q)
            VSEL_MDATA: wb_data = bus.mdata;
            VSEL_IMM:   wb_data = W'($signed(imm_v_q));
            VSEL_PC:    wb_data = W'(bus.pc);
            default:    wb_data = c_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            rn_q     <= '0;
            rm_q     <= '0;
            rd_q     <= '0;
            shift_q  <= '0;
            aluop_q  <= '0;
            asel_q   <= 1'b0;
            bsel_q   <= 1'b0;
            write_q  <= 1'b0;
            loads_q  <= 1'b0;
            vsel_q   <= '0;
            imm_b_q  <= '0;
            imm_v_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.cmd_valid && ready_q) begin
                    rn_q    <= bus.cmd_rn;
                    rm_q    <= bus.cmd_rm;
                    rd_q    <= bus.cmd_rd;
                    shift_q <= bus.cmd_shift;
                    aluop_q <= bus.cmd_aluop;
                    asel_q  <= bus.cmd_asel;
                    bsel_q  <= bus.cmd_bsel;
                    write_q <= bus.cmd_write;
                    loads_q <= bus.cmd_loads;
                    vsel_q  <= bus.cmd_vsel;
                    imm_b_q <= bus.cmd_imm_b;
                    imm_v_q <= bus.cmd_imm_v;
                    ready_q <= 1'b0;
                    state   <= FETCH;
                end
                FETCH: begin
                    a_q   <= rdata_a;
                    b_q   <= rdata_b;
                    state <= EXEC;
                end
                EXEC: begin
                    c_q <= alu_res;
                    if (loads_q) status_q <= {(alu_res == '0), alu_res[W-1], ovf};
                    state <= WB;
                end
                default: begin  // WB: register write happens in dp_regfile
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.done      = done_q;
    assign bus.status    = status_q;
    assign bus.dp_out    = c_q;

endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: self-checking bench for datapath_seq (default parameters).
// Directed vector table, randomized commands against an integer-arithmetic
// reference model, back-to-back handshake timing and mid-command reset.
module tb_datapath_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    datapath_seq_if bus ();

    datapath_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] rn, rm, rd;
        logic [1:0] shift;
        logic       asel, bsel;
        logic [1:0] aluop;
        logic [3:0] vsel;
        logic       write, loads;
        logic [4:0] imm_b;
        logic [7:0] imm_v;
    } cmd_t;

    typedef struct {
        cmd_t        c;
        logic [15:0] md;
        logic [8:0]  p;
        logic [15:0] exp_c;
        logic [2:0]  exp_s;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [15:0] m_r [8];
    logic [15:0] m_c;
    logic [2:0]  m_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cmd_t mk(input int rn, rm, rd, shift, asel, bsel, aluop, vsel,
                                write, loads, imm_b, imm_v);
        cmd_t c;
        c.rn = 3'(rn); c.rm = 3'(rm); c.rd = 3'(rd); c.shift = 2'(shift);
        c.asel = 1'(asel); c.bsel = 1'(bsel); c.aluop = 2'(aluop); c.vsel = 4'(vsel);
        c.write = 1'(write); c.loads = 1'(loads); c.imm_b = 5'(imm_b); c.imm_v = 8'(imm_v);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        m_c = '0;
        m_s = '0;
    endtask

    // Integer-level semantics of one command.
    task automatic model(input cmd_t c, input logic [15:0] md, input logic [8:0] p);
        logic [15:0] a, b, res, wb;
        int sa, sb, full;
        logic v;
        a = c.asel ? 16'd0 : m_r[c.rn];
        b = m_r[c.rm];
        case (c.shift)
            2'd1: b = b << 1;
            2'd2: b = b >> 1;
            2'd3: b = 16'($signed(b) >>> 1);
            default: ;
        endcase
        if (c.bsel) b = 16'($signed(c.imm_b));
        sa = int'($signed(a));
        sb = int'($signed(b));
        v = 1'b0;
        case (c.aluop)
            2'd0, 2'd1: begin
                full = (c.aluop == 2'd0) ? sa + sb : sa - sb;
                res = full[15:0];
                v = (full > 32767) || (full < -32768);
`ifdef DATAPATH_SAT_EN
                if (v) res = (full > 0) ? 16'h7FFF : 16'h8000;
`endif
            end
            2'd2: res = a & b;
            default: res = ~b;
        endcase
        m_c = res;
        if (c.loads) m_s = {res == 16'd0, res[15], v};
        case (c.vsel)
            4'b1000: wb = md;
            4'b0100: wb = 16'($signed(c.imm_v));
            4'b0010: wb = {7'd0, p};
            default: wb = m_c;
        endcase
        if (c.write) m_r[c.rd] = wb;
    endtask

    task automatic drive(input cmd_t c);
        bus.cmd_rn = c.rn; bus.cmd_rm = c.rm; bus.cmd_rd = c.rd;
        bus.cmd_shift = c.shift; bus.cmd_asel = c.asel; bus.cmd_bsel = c.bsel;
        bus.cmd_aluop = c.aluop; bus.cmd_vsel = c.vsel; bus.cmd_write = c.write;
        bus.cmd_loads = c.loads; bus.cmd_imm_b = c.imm_b; bus.cmd_imm_v = c.imm_v;
    endtask

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        int r;
        c = mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
               0, $urandom, $urandom, $urandom, $urandom);
        r = $urandom_range(0, 5);
        c.vsel = (r < 4) ? 4'(1 << r) : 4'($urandom);
        return c;
    endfunction

    // One full command; returns at the sample point just after the WB edge.
    task automatic do_cmd(input cmd_t c, input logic [15:0] md, input logic [8:0] p);
        int n = 0;
        drive(c);
        bus.mdata = md;
        bus.pc = p;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) begin
            chk("accept_timeout", 1, 0);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;                 // accept edge
        bus.cmd_valid = 1'b0;
        drive(rnd_cmd());                   // later field changes must be ignored
        @(posedge clk); #1;
        chk("busy_ready", bus.cmd_ready, 0);
        chk("early_done1", bus.done, 0);
        @(posedge clk); #1;
        chk("early_done2", bus.done, 0);
        @(posedge clk); #1;                 // WB edge
        chk("done_pulse", bus.done, 1);
        chk("ready_back", bus.cmd_ready, 1);
        model(c, md, p);
        chk("dp_out", bus.dp_out, m_c);
        chk("status", bus.status, m_s);
        bus.mdata = 16'($urandom);
        bus.pc = 9'($urandom);
    endtask

    task automatic readback(input int r);
        do_cmd(mk(0, r, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0), 16'd0, 9'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    vec_t vecs [15];

    initial begin
        cmd_t c;
        bus.cmd_valid = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus.mdata = '0;
        bus.pc = '0;
        do_reset();
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_dp_out", bus.dp_out, 0);
        chk("rst_status", bus.status, 0);

        //           rn rm rd sh as bs op vsel    w  l  imb imv
        vecs[0]  = '{mk(0, 0, 3, 0, 0, 0, 0, 4'b1000, 1, 0, 0, 0), 16'h0001, 9'h0, 16'h0000, 3'b000};
        vecs[1]  = '{mk(0, 0, 5, 0, 0, 0, 0, 4'b1000, 1, 0, 0, 0), 16'h0001, 9'h0, 16'h0000, 3'b000};
        vecs[2]  = '{mk(5, 3, 2, 0, 0, 0, 0, 4'b0001, 1, 1, 0, 0), 16'h0000, 9'h0, 16'h0002, 3'b000};
        vecs[3]  = '{mk(0, 0, 0, 0, 0, 0, 0, 4'b0100, 1, 0, 0, 2), 16'h0000, 9'h0, 16'h0000, 3'b000};
        vecs[4]  = '{mk(0, 0, 2, 0, 0, 0, 0, 4'b0100, 1, 0, 0, 2), 16'h0000, 9'h0, 16'h0004, 3'b000};
        vecs[5]  = '{mk(0, 2, 7, 0, 0, 0, 1, 4'b0001, 0, 1, 0, 0), 16'h0000, 9'h0, 16'h0000, 3'b100};
        vecs[6]  = '{mk(0, 2, 0, 0, 1, 0, 0, 4'b0001, 0, 0, 0, 0), 16'h0000, 9'h0, 16'h0002, 3'b100};
        vecs[7]  = '{mk(0, 0, 1, 0, 0, 0, 0, 4'b1000, 1, 0, 0, 0), 16'h7FFF, 9'h0, 16'h0004, 3'b100};
`ifdef DATAPATH_SAT_EN
        vecs[8]  = '{mk(1, 0, 0, 0, 0, 1, 0, 4'b0001, 0, 1, 1, 0), 16'h0000, 9'h0, 16'h7FFF, 3'b001};
`else
        vecs[8]  = '{mk(1, 0, 0, 0, 0, 1, 0, 4'b0001, 0, 1, 1, 0), 16'h0000, 9'h0, 16'h8000, 3'b011};
`endif
        vecs[9]  = '{mk(0, 0, 4, 0, 0, 0, 0, 4'b1000, 1, 0, 0, 0), 16'h8002, 9'h0, 16'h0004, 3'b011 ^ 3'b000};
        vecs[10] = '{mk(0, 4, 6, 3, 0, 0, 3, 4'b0010, 1, 1, 0, 0), 16'h0000, 9'h1AB, 16'h3FFE, 3'b000};
        vecs[11] = '{mk(0, 6, 0, 0, 1, 0, 0, 4'b0001, 0, 0, 0, 0), 16'h0000, 9'h0, 16'h01AB, 3'b000};
        vecs[12] = '{mk(1, 4, 7, 0, 0, 0, 2, 4'b1100, 1, 1, 0, 9), 16'h5555, 9'h0, 16'h0002, 3'b000};
        vecs[13] = '{mk(0, 7, 0, 0, 1, 0, 0, 4'b0001, 0, 0, 0, 0), 16'h0000, 9'h0, 16'h0002, 3'b000};
        vecs[14] = '{mk(0, 5, 0, 0, 1, 0, 3, 4'b0001, 0, 1, 0, 0), 16'h0000, 9'h0, 16'hFFFE, 3'b010};
`ifdef DATAPATH_SAT_EN
        vecs[9].exp_s = 3'b001;
`endif

        foreach (vecs[i]) begin
            do_cmd(vecs[i].c, vecs[i].md, vecs[i].p);
            chk($sformatf("vec%0d_c", i), bus.dp_out, vecs[i].exp_c);
            chk($sformatf("vec%0d_s", i), bus.status, vecs[i].exp_s);
        end

        // randomized commands against the model, then every register read back
        for (int i = 0; i < 150; i++) begin
            c = rnd_cmd();
            if ((i % 5) == 0) c.rm = c.rd;  // exercise reuse of the destination
            do_cmd(c, 16'($urandom), 9'($urandom));
        end
        for (int r = 0; r < 8; r++) readback(r);

        // cmd_valid held high: accepts every 4 cycles, 1-cycle done 3 after each
        c = mk(0, 1, 0, 0, 1, 0, 0, 4'b0001, 0, 0, 0, 0);
        drive(c);
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_done%0d", i), bus.done, (i % 4) == 3);
            chk($sformatf("b2b_ready%0d", i), bus.cmd_ready, (i % 4) == 3);
        end
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) model(c, 16'd0, 9'd0);
        chk("b2b_dp_out", bus.dp_out, m_c);
        @(posedge clk); #1;
        chk("b2b_idle_done", bus.done, 0);

        // reset while a write command sits in EXEC
        c = mk(0, 0, 3, 0, 0, 0, 0, 4'b1000, 1, 1, 0, 0);
        drive(c);
        bus.mdata = 16'hBEEF;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;                 // accept
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;                 // now in EXEC
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        chk("abort_ready", bus.cmd_ready, 1);
        chk("abort_done", bus.done, 0);
        chk("abort_dp_out", bus.dp_out, 0);
        chk("abort_status", bus.status, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", bus.done, 0);
        end
        for (int r = 0; r < 8; r++) readback(r);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
